// File: rtl/deser_pkg.sv
// Shared widths and index helpers for the 8-bit serial-to-parallel deserializer.
package deser_pkg;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = 3'(DATA_W - 1);

    typedef logic [DATA_W-1:0] byte_t;

    // Maps the arrival index of a bit to its position in the assembled byte.
    function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx,
                                                 input logic             msb_first);
        return msb_first ? (LAST_IDX - idx) : idx;
    endfunction
endpackage

// File: rtl/bit_demux_1to8.sv
// One-hot write enable for a single bit of the assembly register; all zeros when idle.
module bit_demux_1to8
    import deser_pkg::*;
(
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] we_o
);

    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/deserializer_8.sv
// Collects 8 serial bits into a byte with a single-entry output register and
// back-pressure that stalls only the byte-completing bit.
module deserializer_8
    import deser_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] d,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [IDX_W-1:0]  sel
);

    logic [IDX_W-1:0] sel_q, sel_d;
    byte_t            asm_q, asm_d;
    byte_t            d_q, d_d;
    logic             dv_q, dv_d;

    logic             xfer;
    logic             complete;
    logic [IDX_W-1:0] wr_pos;
    byte_t            we;

    // The last bit may only land once the output register has room for the byte.
    assign s_ready  = !((sel_q == LAST_IDX) && dv_q && !d_ready);
    assign xfer     = s_valid && s_ready;
    assign complete = xfer && (sel_q == LAST_IDX);
    assign wr_pos   = bit_pos(sel_q, MSB_FIRST);

    bit_demux_1to8 u_demux (
        .idx_i (wr_pos),
        .en_i  (xfer),
        .we_o  (we)
    );

    always_comb begin
        sel_d = xfer ? (sel_q + 1'b1) : sel_q;
        asm_d = (asm_q & ~we) | (we & {DATA_W{s_data}});
        d_d   = complete ? asm_d : d_q;
        dv_d  = dv_q;
        if (dv_q && d_ready) begin
            dv_d = 1'b0;
        end
        if (complete) begin
            dv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            asm_q <= '0;
            d_q   <= '0;
            dv_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            asm_q <= asm_d;
            d_q   <= d_d;
            dv_q  <= dv_d;
        end
    end

    assign d       = d_q;
    assign d_valid = dv_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_deserializer_8.sv
// Self-checking bench: LSB-first and MSB-first instances driven by one stream,
// compared against a bit-list reference model and an in-order byte scoreboard.
module tb_deserializer_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_data = 1'b0;
    logic       s_valid = 1'b0;
    logic       d_ready = 1'b0;
    logic       rdy0, rdy1, dv0, dv1;
    logic [7:0] d0, d1;
    logic [2:0] sel0, sel1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: bits received for the current byte, output occupancy.
    int         m_cnt = 0;
    logic       m_bits [8];
    logic       m_occ = 1'b0;
    logic [7:0] m_d0 = 8'h00;
    logic [7:0] m_d1 = 8'h00;
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    logic       last_xfer;

    always #5 clk = ~clk;

    deserializer_8 #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy0),
        .d(d0), .d_valid(dv0), .d_ready(d_ready), .sel(sel0)
    );

    deserializer_8 #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy1),
        .d(d1), .d_valid(dv1), .d_ready(d_ready), .sel(sel1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_occ = 1'b0;
        m_d0  = 8'h00;
        m_d1  = 8'h00;
        sb0.delete();
        sb1.delete();
    endtask

    // Drives one cycle at the falling edge, checks outputs, then advances the model
    // to account for the following rising edge.
    task automatic cycle(input logic sv, input logic sd, input logic dr);
        logic exp_rdy, consume;
        logic [7:0] b0, b1;
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        d_ready = dr;
        #1;
        exp_rdy = !((m_cnt == 7) && m_occ && !dr);
        check_val("sel0", 32'(sel0), m_cnt);
        check_val("sel1", 32'(sel1), m_cnt);
        check_val("d_valid0", 32'(dv0), 32'(m_occ));
        check_val("d_valid1", 32'(dv1), 32'(m_occ));
        check_val("d0", 32'(d0), 32'(m_d0));
        check_val("d1", 32'(d1), 32'(m_d1));
        check_val("s_ready0", 32'(rdy0), 32'(exp_rdy));
        check_val("s_ready1", 32'(rdy1), 32'(exp_rdy));
        consume = m_occ && dr;
        if (consume && sb0.size() > 0) begin
            check_val("sb_order0", 32'(d0), 32'(sb0.pop_front()));
            check_val("sb_order1", 32'(d1), 32'(sb1.pop_front()));
        end
        if (consume) m_occ = 1'b0;
        last_xfer = sv && exp_rdy;
        if (last_xfer) begin
            m_bits[m_cnt] = sd;
            if (m_cnt == 7) begin
                for (int i = 0; i < 8; i++) begin
                    b0[i]   = m_bits[i];
                    b1[7-i] = m_bits[i];
                end
                m_d0  = b0;
                m_d1  = b1;
                m_occ = 1'b1;
                sb0.push_back(b0);
                sb1.push_back(b1);
            end
            m_cnt = (m_cnt + 1) % 8;
        end
    endtask

    // Asserts reset away from any clock edge and checks it takes effect at once.
    task automatic apply_reset();
        s_valid = 1'b0;
        d_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_sel0", 32'(sel0), 32'd0);
        check_val("rst_sel1", 32'(sel1), 32'd0);
        check_val("rst_dv0", 32'(dv0), 32'd0);
        check_val("rst_dv1", 32'(dv1), 32'd0);
        check_val("rst_d0", 32'(d0), 32'd0);
        check_val("rst_d1", 32'(d1), 32'd0);
        check_val("rst_rdy0", 32'(rdy0), 32'd1);
        @(posedge clk);
        #1;
        check_val("rst_hold_sel0", 32'(sel0), 32'd0);
        check_val("rst_hold_rdy1", 32'(rdy1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_pct, input int rdy_pct);
        int tries;
        for (int i = 0; i < 8; i++) begin
            tries = 0;
            do begin
                cycle($urandom_range(0, 99) >= gap_pct, v[i], $urandom_range(0, 99) < rdy_pct);
                tries++;
            end while (!last_xfer && tries < 100);
            if (!last_xfer) check_val("bit_timeout", 32'(tries), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] pat, a, b, c, e;
        int         tries;

        apply_reset();

        // LSB-first stream of 0xAD into both bit orders, consumer always ready.
        pat = 8'hAD;
        for (int i = 0; i < 8; i++) cycle(1'b1, pat[i], 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check_val("ad_lsb", 32'(d0), 32'h0AD);
        check_val("ad_msb", 32'(d1), 32'h0B5);
        check_val("ad_dv", 32'(dv0), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("ad_dv_one_cycle", 32'(dv0), 32'd0);

        // Consumer stalled across two bytes; release coincides with completion.
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 0; i < 8; i++) cycle(1'b1, a[i], 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, b[i], 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, b[7], 1'b0);
            check_val("stall_rdy", 32'(rdy0), 32'd0);
            check_val("stall_hold", 32'(d0), 32'(a));
        end
        cycle(1'b1, b[7], 1'b1);
        check_val("release_rdy", 32'(rdy0), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("second_byte0", 32'(d0), 32'(b));
        check_val("second_byte1", 32'(d1), 32'(bitrev(b)));
        check_val("no_bubble", 32'(dv0), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);

        // Random gaps and back-pressure across 16 bytes.
        for (int n = 0; n < 16; n++) send_byte(8'($urandom), 30, 50);
        tries = 0;
        while (m_occ && tries < 50) begin
            cycle(1'b0, 1'b0, 1'b1);
            tries++;
        end
        cycle(1'b0, 1'b0, 1'b0);
        check_val("sb_drained", 32'(sb0.size()), 32'd0);

        // Reset mid-byte with an unconsumed byte pending.
        c = 8'($urandom);
        for (int i = 0; i < 8; i++) cycle(1'b1, c[i], 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("pre_rst_dv", 32'(dv0), 32'd1);
        check_val("pre_rst_sel", 32'(sel0), 32'd5);
        apply_reset();
        e = 8'($urandom);
        for (int i = 0; i < 8; i++) cycle(1'b1, e[i], 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check_val("post_rst_byte0", 32'(d0), 32'(e));
        check_val("post_rst_byte1", 32'(d1), 32'(bitrev(e)));
        cycle(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/deserializer_8.md
DESERIALIZER_8 -- requirements
Module: deserializer_8

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0: 0 means the first received bit lands in d[0]; 1 means the first received bit lands in d[7].
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is asynchronous and active-high.
REQ-004 SHALL have port s_data, input, 1, serial data bit.
REQ-005 SHALL have port s_valid, input, 1, s_data is valid this cycle.
REQ-006 SHALL have port s_ready, output, 1, block can accept a bit this cycle.
REQ-007 SHALL have port d, output, 8, assembled parallel byte.
REQ-008 SHALL have port d_valid, output, 1, d holds an unconsumed byte.
REQ-009 SHALL have port d_ready, input, 1, consumer takes d this cycle.
REQ-010 SHALL have port sel, output, 3, index of the assembly bit the next accepted bit will write.

Function
REQ-011 SHALL accept a bit only on a cycle where s_valid and s_ready are both 1 (a bit transfer).
REQ-012 SHALL write each accepted bit into an 8-bit assembly register at position sel when MSB_FIRST=0, and at position 7-sel when MSB_FIRST=1.
REQ-013 SHALL increment sel by 1 on every bit transfer, wrapping 7 -> 0, and hold sel otherwise.
REQ-014 SHALL, on the bit transfer at sel=7, load d with the completed byte (including that bit) and set d_valid on the next clock edge, giving 1-cycle latency from the 8th bit to d_valid.
REQ-015 SHALL clear d_valid on a cycle where d_valid and d_ready are both 1, unless a new byte completes in that same cycle.
REQ-016 SHALL, when a byte completes in the same cycle as d is consumed, load the new byte into d and keep d_valid at 1 with no bubble.
REQ-017 SHALL hold d stable while d_valid=1 and d_ready=0.
REQ-018 SHALL drive s_ready = NOT (sel==7 AND d_valid AND NOT d_ready); this is combinational and stalls only the 8th bit while the output is occupied.
REQ-019 SHALL accept bits 0..6 of the next byte while the previous byte awaits consumption.
REQ-020 SHALL keep d at its previous value when d_valid=0; d content is don't-care to the consumer.
REQ-021 SHALL treat gaps (s_valid=0) of any length as no-ops, preserving the partial byte and sel.
REQ-022 SHALL never drop or duplicate a bit, and SHALL never overwrite an unconsumed byte.

Reset
REQ-023 SHALL, while rst=1, immediately force sel=0, d=8'h00, d_valid=0, and assembly register=8'h00, independent of clk.
REQ-024 SHALL discard any partial byte when reset is asserted mid-byte; the first bit after reset release is bit index 0.
REQ-025 SHALL drive s_ready=1 during and after reset.

Structure
REQ-026 SHALL take constants DATA_W=8 and IDX_W=3 from shared package deser_pkg.
REQ-027 SHALL implement the index-to-bit-position write enable as sub-module bit_demux_1to8 (inputs: 3-bit index, enable; output: 8-bit one-hot write enable, all zeros when enable=0).
REQ-028 SHALL contain only the assembly register, sel counter, and output register; no FIFO deeper than one byte.

Verification
REQ-029 Bench SHALL cover: reset, then 8 back-to-back bits of 8'b1010_1101 sent LSB first with MSB_FIRST=0 and d_ready=1 -> d=8'hAD and d_valid=1 for exactly one cycle, 1 cycle after the 8th bit.
REQ-030 Bench SHALL cover: the same stream with MSB_FIRST=1 -> d=8'hB5.
REQ-031 Bench SHALL cover: d_ready=0 held while two bytes stream -> first byte held on d; s_ready=0 at sel=7; after d_ready pulses, the second byte appears with no bit loss.
REQ-032 Bench SHALL cover: random s_valid gaps across 16 bytes with a scoreboard compare -> all bytes match, in order.
REQ-033 Bench SHALL cover: rst asserted asynchronously after 5 bits -> sel=0 and d_valid=0 immediately; the next 8 bits form a correct byte.
REQ-034 Bench SHALL cover: byte completion in the same cycle as d_ready=1 with d_valid=1 -> d_valid stays 1 and d updates to the new byte.
